// File: rtl/nn_layer_sequencer_if.sv
// rtl/nn_layer_sequencer_if.sv - handshake bundle between the layer sequencer, input buffer and layer engine
//
// Purpose: groups every non-clock, non-reset signal of nn_layer_sequencer.
// Ports (master = sequencer view):
//   start, in_valid, layer_done, calc_done          : into the sequencer
//   in_ready, layer_go, layer_idx[LW], ld, calc_go,
//   sample_idx[SW], sample_done, batch_done, busy,
//   done, perf_cycles[32]                            : out of the sequencer
// The slave modport is the mirror image for the buffer/engine side.
interface nn_layer_sequencer_if #(
  parameter int NUM_LAYERS  = 2,
  parameter int NUM_SAMPLES = 750
);
  localparam int LW = $clog2(NUM_LAYERS) + 1;
  localparam int SW = $clog2(NUM_SAMPLES) + 1;

  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          layer_go;
  logic [LW-1:0] layer_idx;
  logic          layer_done;
  logic          ld;
  logic          calc_go;
  logic          calc_done;
  logic [SW-1:0] sample_idx;
  logic          sample_done;
  logic          batch_done;
  logic          busy;
  logic          done;
  logic [31:0]   perf_cycles;

  modport master (
    input  start, in_valid, layer_done, calc_done,
    output in_ready, layer_go, layer_idx, ld, calc_go, sample_idx,
           sample_done, batch_done, busy, done, perf_cycles
  );

  modport slave (
    output start, in_valid, layer_done, calc_done,
    input  in_ready, layer_go, layer_idx, ld, calc_go, sample_idx,
           sample_done, batch_done, busy, done, perf_cycles
  );
endinterface

// File: rtl/nn_layer_sequencer.sv
// rtl/nn_layer_sequencer.sv - batch/layer control FSM for the multi-layer perceptron datapath
//
// Purpose: fetches NUM_SAMPLES input vectors, runs each through NUM_LAYERS hidden
// layers and the output calculation by handshake with the layer engine, and
// flags the end of the batch.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - nn_layer_sequencer_if.master (start/in_valid/in_ready, layer_go/
//          layer_idx/layer_done/ld, calc_go/calc_done, sample_idx/sample_done,
//          batch_done, busy, done, perf_cycles)
// Build option: define NN_SEQ_PERF_CNT_EN to build the saturating busy-cycle
// counter behind perf_cycles; otherwise perf_cycles reads 0.
module nn_layer_sequencer #(
  parameter int NUM_LAYERS  = 2,
  parameter int NUM_SAMPLES = 750
) (
  input  logic                  clk,
  input  logic                  rst,
  nn_layer_sequencer_if.master  bus
);
  localparam int LW = $clog2(NUM_LAYERS) + 1;
  localparam int SW = $clog2(NUM_SAMPLES) + 1;
  localparam logic [LW-1:0] LAST_LAYER  = LW'(NUM_LAYERS - 1);
  localparam logic [SW-1:0] LAST_SAMPLE = SW'(NUM_SAMPLES - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LAYER_GO, LAYER_WAIT, CALC_GO, CALC_WAIT, FINISH
  } state_t;

  state_t        state;
  logic [LW-1:0] layer_idx;
  logic [SW-1:0] sample_idx;
  logic          ld;
  logic          sample_done;

  // ld and sample_done are issued one cycle after the engine's ack while the
  // FSM is still in the WAIT state, so the index they qualify is still the
  // finished one; the index advance happens on the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      layer_idx   <= '0;
      sample_idx  <= '0;
      ld          <= 1'b0;
      sample_done <= 1'b0;
    end else begin
      ld          <= 1'b0;
      sample_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sample_idx <= '0;
            state      <= FETCH;
          end
        end
        FETCH: begin
          if (bus.in_valid) begin
            layer_idx <= '0;
            state     <= LAYER_GO;
          end
        end
        LAYER_GO: state <= LAYER_WAIT;
        LAYER_WAIT: begin
          if (ld) begin
            if (layer_idx == LAST_LAYER) begin
              state <= CALC_GO;
            end else begin
              layer_idx <= layer_idx + LW'(1);
              state     <= LAYER_GO;
            end
          end else if (bus.layer_done) begin
            ld <= 1'b1;
          end
        end
        CALC_GO: state <= CALC_WAIT;
        CALC_WAIT: begin
          if (sample_done) begin
            if (sample_idx == LAST_SAMPLE) begin
              state <= FINISH;
            end else begin
              sample_idx <= sample_idx + SW'(1);
              state      <= FETCH;
            end
          end else if (bus.calc_done) begin
            sample_done <= 1'b1;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state == FETCH);
  assign bus.layer_go    = (state == LAYER_GO);
  assign bus.calc_go     = (state == CALC_GO);
  assign bus.batch_done  = (state == FINISH);
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == IDLE);
  assign bus.layer_idx   = layer_idx;
  assign bus.sample_idx  = sample_idx;
  assign bus.ld          = ld;
  assign bus.sample_done = sample_done;

`ifdef NN_SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles;

  // Cleared as a batch launches, then counts every non-IDLE cycle; the value
  // stays readable in IDLE until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles <= '0;
    end else if (state == IDLE) begin
      if (bus.start) perf_cycles <= '0;
    end else if (perf_cycles != 32'hFFFF_FFFF) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end

  assign bus.perf_cycles = perf_cycles;
`else
  assign bus.perf_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb/tb_nn_layer_sequencer.sv - scoreboard bench for nn_layer_sequencer
module tb_nn_layer_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nn_layer_sequencer_if #(.NUM_LAYERS(3), .NUM_SAMPLES(4)) b1 ();
  nn_layer_sequencer_if #(.NUM_LAYERS(1), .NUM_SAMPLES(1)) b2 ();

  nn_layer_sequencer #(.NUM_LAYERS(3), .NUM_SAMPLES(4)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  nn_layer_sequencer #(.NUM_LAYERS(1), .NUM_SAMPLES(1)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  // event kinds: 1 layer_go, 2 ld, 3 calc_go, 4 sample_done, 5 batch_done
  typedef struct {int kind; int sidx; int lidx; int delta;} exp_t;
  exp_t q1[$];
  exp_t q2[$];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int last1 = 0;
  int last2 = 0;
  int busy_cnt = 0;
  bit count_en = 0;

  int   d1 = 2;
  bit   spur = 0;
  logic eng_ld = 1'b0, eng_cd = 1'b0, spur_ld = 1'b0, spur_cd = 1'b0;
  assign b1.layer_done = eng_ld | spur_ld;
  assign b1.calc_done  = eng_cd | spur_cd;

  task automatic chk(input string name, input longint got, input longint want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, want);
  endtask

  task automatic push(input int which, input exp_t e);
    if (which == 1) q1.push_back(e); else q2.push_back(e);
  endtask

  task automatic push_batch(input int which, input int nl, input int ns, input int d, input int first_dt);
    for (int s = 0; s < ns; s++) begin
      for (int l = 0; l < nl; l++) begin
        push(which, '{1, s, l, (l > 0) ? 1 : ((s > 0) ? 2 : first_dt)});
        push(which, '{2, s, l, d + 1});
      end
      push(which, '{3, s, nl - 1, 1});
      push(which, '{4, s, nl - 1, d + 1});
    end
    push(which, '{5, ns - 1, nl - 1, 1});
  endtask

  task automatic sb(input int which, input int kind, input int sidx, input int lidx);
    exp_t e;
    int   last;
    int   sz;
    last = (which == 1) ? last1 : last2;
    sz   = (which == 1) ? q1.size() : q2.size();
    n_total++;
    if (sz == 0) begin
      $display("FAIL dut%0d unexpected event kind=%0d s=%0d l=%0d cycle=%0d", which, kind, sidx, lidx, cyc);
    end else begin
      if (which == 1) e = q1.pop_front(); else e = q2.pop_front();
      if (e.kind == kind && e.sidx == sidx && e.lidx == lidx && (e.delta < 0 || cyc - last == e.delta))
        n_pass++;
      else
        $display("FAIL dut%0d event: got kind=%0d s=%0d l=%0d dt=%0d, expected kind=%0d s=%0d l=%0d dt=%0d",
                 which, kind, sidx, lidx, cyc - last, e.kind, e.sidx, e.lidx, e.delta);
    end
    if (which == 1) last1 = cyc; else last2 = cyc;
  endtask

  task automatic wait_empty(input int which, input int budget);
    int n = 0;
    while (((which == 1) ? q1.size() : q2.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk((which == 1) ? "dut1 expected events drained" : "dut2 expected events drained",
        (which == 1) ? q1.size() : q2.size(), 0);
    if (which == 1) q1.delete(); else q2.delete();
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // monitor
  initial forever begin
    @(negedge clk);
    if (count_en && b1.busy) busy_cnt++;
    if (b1.layer_go)    sb(1, 1, int'(b1.sample_idx), int'(b1.layer_idx));
    if (b1.ld)          sb(1, 2, int'(b1.sample_idx), int'(b1.layer_idx));
    if (b1.calc_go)     sb(1, 3, int'(b1.sample_idx), int'(b1.layer_idx));
    if (b1.sample_done) sb(1, 4, int'(b1.sample_idx), int'(b1.layer_idx));
    if (b1.batch_done)  sb(1, 5, int'(b1.sample_idx), int'(b1.layer_idx));
    if (b2.layer_go)    sb(2, 1, int'(b2.sample_idx), int'(b2.layer_idx));
    if (b2.ld)          sb(2, 2, int'(b2.sample_idx), int'(b2.layer_idx));
    if (b2.calc_go)     sb(2, 3, int'(b2.sample_idx), int'(b2.layer_idx));
    if (b2.sample_done) sb(2, 4, int'(b2.sample_idx), int'(b2.layer_idx));
    if (b2.batch_done)  sb(2, 5, int'(b2.sample_idx), int'(b2.layer_idx));
  end

  // layer engine model for dut1: ack d1 cycles after each go
  initial forever begin
    @(negedge clk);
    if (b1.layer_go) begin
      repeat (d1) @(negedge clk);
      eng_ld = 1'b1;
      @(negedge clk);
      eng_ld = 1'b0;
    end else if (b1.calc_go) begin
      if (spur) begin
        eng_cd = 1'b1;
        eng_ld = 1'b1;
        @(negedge clk);
        eng_cd = 1'b0;
        eng_ld = 1'b0;
        repeat (d1 - 1) @(negedge clk);
      end else begin
        repeat (d1) @(negedge clk);
      end
      eng_cd = 1'b1;
      @(negedge clk);
      eng_cd = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    longint perf_hold;
    rst = 1'b1;
    b1.start = 1'b0; b1.in_valid = 1'b0;
    b2.start = 1'b0; b2.in_valid = 1'b1;
    b2.layer_done = 1'b1; b2.calc_done = 1'b1;
    repeat (2) @(negedge clk);

    chk("reset done", b1.done, 1);
    chk("reset busy", b1.busy, 0);
    chk("reset in_ready", b1.in_ready, 0);
    chk("reset layer_idx", b1.layer_idx, 0);
    chk("reset sample_idx", b1.sample_idx, 0);
    chk("reset perf_cycles", b1.perf_cycles, 0);
    chk("reset ld", b1.ld, 0);
    chk("reset batch_done", b1.batch_done, 0);
    rst = 1'b0;
    @(negedge clk);

    // spurious acks in IDLE
    spur_ld = 1'b1; spur_cd = 1'b1;
    @(negedge clk);
    spur_ld = 1'b0; spur_cd = 1'b0;
    @(negedge clk);
    chk("idle spurious done", b1.done, 1);
    chk("idle spurious busy", b1.busy, 0);

    // full batch, 2-cycle engine acks
    b1.in_valid = 1'b1; d1 = 2;
    push_batch(1, 3, 4, 2, -1);
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    wait_empty(1, 500);
    @(negedge clk);
    chk("batch1 done", b1.done, 1);

    // in_valid held low in FETCH, spurious acks in FETCH and CALC_GO
    b1.in_valid = 1'b0; spur = 1;
    push_batch(1, 3, 4, 2, -1);
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin spur_ld = 1'b1; spur_cd = 1'b1; end
      if (i == 2) begin spur_ld = 1'b0; spur_cd = 1'b0; end
      @(negedge clk);
      chk("fetch stall in_ready", b1.in_ready, 1);
      chk("fetch stall layer_go", b1.layer_go, 0);
    end
    b1.in_valid = 1'b1;
    @(negedge clk);
    chk("layer_go one cycle after in_valid", b1.layer_go, 1);
    wait_empty(1, 500);
    spur = 0;
    @(negedge clk);

    // reset during LAYER_WAIT of sample 2, then a fresh batch
    push_batch(1, 3, 4, 2, -1);
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (b1.layer_go && b1.sample_idx == 2) found = 1;
    end
    chk("reached sample 2", found, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    q1.delete();
    #1;
    chk("midrun reset done", b1.done, 1);
    chk("midrun reset busy", b1.busy, 0);
    chk("midrun reset layer_idx", b1.layer_idx, 0);
    chk("midrun reset sample_idx", b1.sample_idx, 0);
    chk("midrun reset layer_go", b1.layer_go, 0);
    chk("midrun reset ld", b1.ld, 0);
    chk("midrun reset perf_cycles", b1.perf_cycles, 0);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_batch(1, 3, 4, 2, -1);
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    wait_empty(1, 500);
    @(negedge clk);
    chk("post-reset batch done", b1.done, 1);

    // busy-cycle counter, 1-cycle acks
    d1 = 1;
    busy_cnt = 0;
    count_en = 1;
    push_batch(1, 3, 4, 1, -1);
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    wait_empty(1, 500);
    @(negedge clk);
    count_en = 0;
    chk("busy cycles in 1-ack batch", busy_cnt, 53);
`ifdef NN_SEQ_PERF_CNT_EN
    chk("perf_cycles", b1.perf_cycles, busy_cnt);
`else
    chk("perf_cycles", b1.perf_cycles, 0);
`endif
    perf_hold = b1.perf_cycles;
    repeat (3) @(negedge clk);
    chk("perf_cycles holds in idle", b1.perf_cycles, perf_hold);

    // dut2: 1 layer, 1 sample, start and acks held high -> back-to-back batches
    push_batch(2, 1, 1, 1, -1);
    push_batch(2, 1, 1, 1, 3);
    b2.start = 1'b1;
    for (int i = 0; i < 100 && q2.size() > 4; i++) @(negedge clk);
    b2.start = 1'b0;
    wait_empty(2, 100);
    repeat (12) @(negedge clk);
    chk("dut2 idle after two batches", b2.done, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
